// File: rtl/grf_write_commit_pkg.sv
// Shared register-file geometry and the architectural register indices that
// the RegDst selector and the register file both refer to.
package grf_defs;
  localparam int GRF_DEPTH = 32;
  localparam int GRF_AW    = 5;
  localparam int GRF_DW    = 32;

  localparam logic [GRF_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [GRF_AW-1:0] REG_RA   = 5'd31;

  // $0 is hard-wired; nothing written to it is ever observable.
  function automatic logic is_zero_reg(input logic [GRF_AW-1:0] idx);
    return idx == REG_ZERO;
  endfunction
endpackage

// File: rtl/grf_write_commit_if.sv
// Register-file access bundle: one write port (WE/A3/WD/PC) and two
// combinational read ports (A1->RD1, A2->RD2), plus the commit counter.
interface grf_write_commit_if #(
  parameter int CNT_W = 32
);
  import grf_defs::*;

  // WE is a plain enable with no back-pressure: when WE is high at a rising
  // clk edge (reset low) the write commits on that edge, unconditionally.
  logic              WE;
  logic [GRF_AW-1:0] A1;
  logic [GRF_AW-1:0] A2;
  logic [GRF_AW-1:0] A3;
  logic [GRF_DW-1:0] WD;
  logic [GRF_DW-1:0] PC;
  logic [GRF_DW-1:0] RD1;
  logic [GRF_DW-1:0] RD2;
  logic [CNT_W-1:0]  WrCnt;

  modport master (
    output WE, A1, A2, A3, WD, PC,
    input  RD1, RD2, WrCnt
  );

  modport slave (
    input  WE, A1, A2, A3, WD, PC,
    output RD1, RD2, WrCnt
  );
endinterface

// File: rtl/grf_write_commit_read_port.sv
// One combinational read port. Priority: $0 reads zero, then same-cycle
// write bypass (when enabled), then the stored array value.
module grf_read_port
  import grf_defs::*;
#(
  parameter bit BYPASS = 1'b1
) (
  input  logic [GRF_AW-1:0] idx_i,
  input  logic [GRF_DW-1:0] reg_val_i,
  input  logic              we_i,
  input  logic [GRF_AW-1:0] wa_i,
  input  logic [GRF_DW-1:0] wd_i,
  output logic [GRF_DW-1:0] rd_o
);
  always_comb begin
    rd_o = reg_val_i;
    if (is_zero_reg(idx_i)) begin
      rd_o = '0;
    end else if (BYPASS && we_i && (wa_i == idx_i)) begin
      rd_o = wd_i;
    end
  end
endmodule

// File: rtl/grf_write_commit.sv
// 32 x 32-bit MIPS general register file with commit trace and a
// committed-write counter; $0 writes are counted and traced but not stored.
module grf_write_commit
  import grf_defs::*;
#(
  parameter bit BYPASS = 1'b1,
  parameter bit TRACE  = 1'b1,
  parameter int CNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  grf_write_commit_if.slave  bus
);
  logic [GRF_DW-1:0] regs_q [GRF_DEPTH];
  logic [CNT_W-1:0]  wr_cnt_q;
  logic [CNT_W-1:0]  wr_cnt_d;
  logic              byp_en;

  assign wr_cnt_d = wr_cnt_q + CNT_W'(1);

  // Storage and counter only ever move when WE is high, so X on A3/WD
  // with WE low cannot reach state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < GRF_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else if (bus.WE) begin
      if (!is_zero_reg(bus.A3)) begin
        regs_q[bus.A3] <= bus.WD;
      end
      wr_cnt_q <= wr_cnt_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (TRACE && !reset && bus.WE) begin
      $display("@%h: $%d <= %h", bus.PC, bus.A3, bus.WD);
    end
  end
`endif

  // While reset is high the array is being cleared, so bypass is suppressed
  // to keep both read ports at zero.
  assign byp_en = bus.WE && !reset;

  grf_read_port #(.BYPASS(BYPASS)) u_rd1 (
    .idx_i     (bus.A1),
    .reg_val_i (regs_q[bus.A1]),
    .we_i      (byp_en),
    .wa_i      (bus.A3),
    .wd_i      (bus.WD),
    .rd_o      (bus.RD1)
  );

  grf_read_port #(.BYPASS(BYPASS)) u_rd2 (
    .idx_i     (bus.A2),
    .reg_val_i (regs_q[bus.A2]),
    .we_i      (byp_en),
    .wa_i      (bus.A3),
    .wd_i      (bus.WD),
    .rd_o      (bus.RD2)
  );

  assign bus.WrCnt = wr_cnt_q;
endmodule

// File: tb/tb_grf_write_commit.sv
// Directed bench: dut_a (bypass on, 32-bit counter, trace on) and dut_b
// (bypass off, 4-bit counter, trace off) receive identical stimulus.
module tb_grf_write_commit;
  logic clk;
  logic reset;
  int   vecs;
  int   fails;

  grf_write_commit_if #(.CNT_W(32)) if_a ();
  grf_write_commit_if #(.CNT_W(4))  if_b ();

  grf_write_commit #(.BYPASS(1'b1), .TRACE(1'b1), .CNT_W(32)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  grf_write_commit #(.BYPASS(1'b0), .TRACE(1'b0), .CNT_W(4)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver tasks
  task automatic drive(input logic we, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    if_a.WE = we; if_a.A1 = a1; if_a.A2 = a2; if_a.A3 = a3; if_a.WD = wd; if_a.PC = pc;
    if_b.WE = we; if_b.A1 = a1; if_b.A2 = a2; if_b.A3 = a3; if_b.WD = wd; if_b.PC = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 5'd5, 5'd31, 5'd0, 32'h0, 32'h0);
    #1;
    vecs++; if (if_a.RD1 !== 32'h0) begin fails++; $display("FAIL por_rd1: got %h want %h", if_a.RD1, 32'h0); end
    vecs++; if (if_a.WrCnt !== 32'h0) begin fails++; $display("FAIL por_cnt: got %h want %h", if_a.WrCnt, 32'h0); end
    tick(); tick();
    reset = 1'b0;
    drive(1'b1, 5'd5, 5'd31, 5'd5, 32'h0000_00AA, 32'h0000_1000);
    tick();
    drive(1'b1, 5'd5, 5'd31, 5'd31, 32'h0000_00BB, 32'h0000_1004);
    tick();
    drive(1'b0, 5'd5, 5'd31, 5'd0, 32'h0, 32'h0);
    vecs++; if (if_a.RD1 !== 32'hAA) begin fails++; $display("FAIL pre_rst_rd1: got %h want %h", if_a.RD1, 32'hAA); end
    vecs++; if (if_a.RD2 !== 32'hBB) begin fails++; $display("FAIL pre_rst_rd2: got %h want %h", if_a.RD2, 32'hBB); end
    vecs++; if (if_a.WrCnt !== 32'd2) begin fails++; $display("FAIL pre_rst_cnt: got %0d want %0d", if_a.WrCnt, 2); end
    // mid-cycle assertion, no clock edge involved
    #2 reset = 1'b1;
    #1;
    vecs++; if (if_a.RD1 !== 32'h0) begin fails++; $display("FAIL rst_rd1_a: got %h want %h", if_a.RD1, 32'h0); end
    vecs++; if (if_a.RD2 !== 32'h0) begin fails++; $display("FAIL rst_rd2_a: got %h want %h", if_a.RD2, 32'h0); end
    vecs++; if (if_a.WrCnt !== 32'h0) begin fails++; $display("FAIL rst_cnt_a: got %h want %h", if_a.WrCnt, 32'h0); end
    vecs++; if (if_b.RD2 !== 32'h0) begin fails++; $display("FAIL rst_rd2_b: got %h want %h", if_b.RD2, 32'h0); end
    vecs++; if (if_b.WrCnt !== 4'h0) begin fails++; $display("FAIL rst_cnt_b: got %h want %h", if_b.WrCnt, 4'h0); end
    drive(1'b1, 5'd5, 5'd31, 5'd5, 32'h0000_0077, 32'h0000_1008);
    #1;
    vecs++; if (if_a.RD1 !== 32'h0) begin fails++; $display("FAIL rst_nobyp: got %h want %h", if_a.RD1, 32'h0); end
    tick();
    vecs++; if (if_a.WrCnt !== 32'h0) begin fails++; $display("FAIL rst_edge_cnt: got %0d want %0d", if_a.WrCnt, 0); end
    drive(1'b0, 5'd5, 5'd31, 5'd0, 32'h0, 32'h0);
    vecs++; if (if_a.RD1 !== 32'h0) begin fails++; $display("FAIL rst_edge_rd1: got %h want %h", if_a.RD1, 32'h0); end
    reset = 1'b0;
  endtask

  task automatic test_write();
    drive(1'b1, 5'd8, 5'd0, 5'd8, 32'h1234_5678, 32'h0000_3000);
    #1;
    vecs++; if (if_a.RD1 !== 32'h1234_5678) begin fails++; $display("FAIL wr_byp_a: got %h want %h", if_a.RD1, 32'h1234_5678); end
    vecs++; if (if_b.RD1 !== 32'h0) begin fails++; $display("FAIL wr_nobyp_b: got %h want %h", if_b.RD1, 32'h0); end
    tick();
    drive(1'b0, 5'd8, 5'd0, 5'd0, 32'h0, 32'h0);
    vecs++; if (if_a.RD1 !== 32'h1234_5678) begin fails++; $display("FAIL wr_rd1_a: got %h want %h", if_a.RD1, 32'h1234_5678); end
    vecs++; if (if_b.RD1 !== 32'h1234_5678) begin fails++; $display("FAIL wr_rd1_b: got %h want %h", if_b.RD1, 32'h1234_5678); end
    vecs++; if (if_a.WrCnt !== 32'd1) begin fails++; $display("FAIL wr_cnt_a: got %0d want %0d", if_a.WrCnt, 1); end
    vecs++; if (if_a.RD2 !== 32'h0) begin fails++; $display("FAIL wr_rd2_zero: got %h want %h", if_a.RD2, 32'h0); end
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 5'd0, 5'd8, 5'd0, 32'hFFFF_FFFF, 32'h0000_3004);
    #1;
    vecs++; if (if_a.RD1 !== 32'h0) begin fails++; $display("FAIL z_byp_rd1: got %h want %h", if_a.RD1, 32'h0); end
    tick();
    drive(1'b0, 5'd0, 5'd8, 5'd0, 32'h0, 32'h0);
    vecs++; if (if_a.RD1 !== 32'h0) begin fails++; $display("FAIL z_rd1_a: got %h want %h", if_a.RD1, 32'h0); end
    vecs++; if (if_a.WrCnt !== 32'd2) begin fails++; $display("FAIL z_cnt_a: got %0d want %0d", if_a.WrCnt, 2); end
    vecs++; if (if_b.WrCnt !== 4'd2) begin fails++; $display("FAIL z_cnt_b: got %0d want %0d", if_b.WrCnt, 2); end
    vecs++; if (if_a.RD2 !== 32'h1234_5678) begin fails++; $display("FAIL z_r8_kept: got %h want %h", if_a.RD2, 32'h1234_5678); end
  endtask

  task automatic test_bypass();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 32'h0000_0011, 32'h0000_3008);
    tick();
    drive(1'b1, 5'd9, 5'd9, 5'd9, 32'h0000_0022, 32'h0000_300C);
    #1;
    vecs++; if (if_a.RD1 !== 32'h22) begin fails++; $display("FAIL byp_rd1_a: got %h want %h", if_a.RD1, 32'h22); end
    vecs++; if (if_a.RD2 !== 32'h22) begin fails++; $display("FAIL byp_rd2_a: got %h want %h", if_a.RD2, 32'h22); end
    vecs++; if (if_b.RD1 !== 32'h11) begin fails++; $display("FAIL nobyp_rd1_b: got %h want %h", if_b.RD1, 32'h11); end
    vecs++; if (if_b.RD2 !== 32'h11) begin fails++; $display("FAIL nobyp_rd2_b: got %h want %h", if_b.RD2, 32'h11); end
    tick();
    drive(1'b0, 5'd9, 5'd9, 5'd0, 32'h0, 32'h0);
    vecs++; if (if_b.RD1 !== 32'h22) begin fails++; $display("FAIL nobyp_after_b: got %h want %h", if_b.RD1, 32'h22); end
    vecs++; if (if_a.WrCnt !== 32'd4) begin fails++; $display("FAIL byp_cnt_a: got %0d want %0d", if_a.WrCnt, 4); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 5'd0, 5'd31, 5'd31, 32'h0000_3008, 32'h0000_3010);
    tick();
    drive(1'b1, 5'd0, 5'd31, 5'd31, 32'h0000_300C, 32'h0000_3014);
    tick();
    drive(1'b0, 5'd0, 5'd31, 5'd0, 32'h0, 32'h0);
    vecs++; if (if_a.RD2 !== 32'h300C) begin fails++; $display("FAIL waw_rd2_a: got %h want %h", if_a.RD2, 32'h300C); end
    vecs++; if (if_b.RD2 !== 32'h300C) begin fails++; $display("FAIL waw_rd2_b: got %h want %h", if_b.RD2, 32'h300C); end
    vecs++; if (if_a.WrCnt !== 32'd6) begin fails++; $display("FAIL waw_cnt_a: got %0d want %0d", if_a.WrCnt, 6); end
  endtask

  task automatic test_idle_x();
    drive(1'b0, 5'd8, 5'd31, 5'bx, 32'hx, 32'hx);
    tick(); tick();
    vecs++; if (if_a.RD1 !== 32'h1234_5678) begin fails++; $display("FAIL idle_rd1: got %h want %h", if_a.RD1, 32'h1234_5678); end
    vecs++; if (if_a.RD2 !== 32'h300C) begin fails++; $display("FAIL idle_rd2: got %h want %h", if_a.RD2, 32'h300C); end
    vecs++; if (if_a.WrCnt !== 32'd6) begin fails++; $display("FAIL idle_cnt: got %0d want %0d", if_a.WrCnt, 6); end
  endtask

  task automatic test_cnt_wrap();
    drive(1'b0, 5'd10, 5'd8, 5'd0, 32'h0, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 5'd10, 5'd8, 5'd10, 32'h0000_00A0 + 32'(i), 32'h0000_4000 + 32'(4 * i));
      tick();
    end
    drive(1'b0, 5'd10, 5'd8, 5'd0, 32'h0, 32'h0);
    vecs++; if (if_b.WrCnt !== 4'd0) begin fails++; $display("FAIL wrap_cnt_b: got %0d want %0d", if_b.WrCnt, 0); end
    vecs++; if (if_a.WrCnt !== 32'd16) begin fails++; $display("FAIL wrap_cnt_a: got %0d want %0d", if_a.WrCnt, 16); end
    vecs++; if (if_b.RD1 !== 32'hAF) begin fails++; $display("FAIL wrap_rd1_b: got %h want %h", if_b.RD1, 32'hAF); end
    vecs++; if (if_b.RD2 !== 32'h0) begin fails++; $display("FAIL wrap_r8_clr: got %h want %h", if_b.RD2, 32'h0); end
  endtask

  initial begin
    vecs  = 0;
    fails = 0;
    test_reset();
    test_write();
    test_zero_reg();
    test_bypass();
    test_back_to_back();
    test_idle_x();
    test_cnt_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
